cpu_icache: RTL

- Direct-mapped instruction cache that feeds the CPU pipeline front end.
- Accepts the 15-bit word PC as cache_request_address and returns a registered cache_line of {address[14:0], valid, instruction[15:0]} plus a cache_miss flag.
- On a miss it bursts an aligned group of words from instruction memory into the cache.
- The pipeline rewinds its PC on cache_miss and retries until the flag clears.

---
 rtl/cpu_icache_if.sv | 22 ++
 rtl/cpu_icache.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_icache_if.sv
// Bundle between cpu_icache, the fetch stage (request/line/miss/flush) and instruction memory.
// slave is the cache's view; master is the combined CPU/memory view.
interface cpu_icache_if;
    logic [14:0] cache_request_address;
    logic [31:0] cache_line;
    logic        cache_miss;
    logic        flush;
    logic        mem_req;
    logic [14:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;

    modport slave (
        input  cache_request_address, flush, mem_ack, mem_data,
        output cache_line, cache_miss, mem_req, mem_addr
    );

    modport master (
        output cache_request_address, flush, mem_ack, mem_data,
        input  cache_line, cache_miss, mem_req, mem_addr
    );
endinterface

// File: rtl/cpu_icache.sv
// Direct-mapped one-word-per-entry instruction cache with aligned burst refill.
// Define ICACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module cpu_icache #(
    parameter int unsigned INDEX_BITS = 8,
    parameter int unsigned BURST_BITS = 2
) (
    input  logic         CLK,
    input  logic         RST,
    cpu_icache_if.slave  bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
`endif
);
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 1 << INDEX_BITS;
    localparam int unsigned TAG_W  = ADDR_W - INDEX_BITS;
    localparam int unsigned LINE_W = ADDR_W + 1 + DATA_W;

    typedef enum logic [1:0] {st_lookup, st_fill, st_resume} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    req_vld_q, req_vld_d;
    logic [DATA_W-1:0]       rd_data_q, rd_data_d;
    logic [TAG_W-1:0]        rd_tag_q, rd_tag_d;
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [LINE_W-1:0]       line_q, line_d;
    logic                    miss_q, miss_d;
    logic                    mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic                    discard_q, discard_d;

    logic [DATA_W-1:0]       data_ram [DEPTH];
    logic [TAG_W-1:0]        tag_ram  [DEPTH];

    logic [INDEX_BITS-1:0]   req_idx_c, look_idx_c, fill_idx_c;
    logic [BURST_BITS-1:0]   burst_nxt_c;
    logic                    hit_c, hit_out_c, wr_en_c, last_word_c, fill_start_c;

    // Lookup stage: RAM outputs and request address are registered together, valid is a flop array.
    always_comb begin
        req_idx_c   = bus.cache_request_address[INDEX_BITS-1:0];
        look_idx_c  = addr_q[INDEX_BITS-1:0];
        fill_idx_c  = mem_addr_q[INDEX_BITS-1:0];
        burst_nxt_c = mem_addr_q[BURST_BITS-1:0] + BURST_BITS'(1);
        last_word_c = &mem_addr_q[BURST_BITS-1:0];
        wr_en_c     = (state_q == st_fill) && bus.mem_ack;
        hit_c       = req_vld_q && valid_q[look_idx_c] &&
                      (rd_tag_q == addr_q[ADDR_W-1:INDEX_BITS]);
        hit_out_c   = hit_c && (state_q == st_lookup);
        addr_d      = bus.cache_request_address;
        req_vld_d   = 1'b1;
        rd_data_d   = data_ram[req_idx_c];
        rd_tag_d    = tag_ram[req_idx_c];
        line_d      = {addr_q, hit_out_c, rd_data_q};
        miss_d      = !hit_out_c;
    end

    // Refill FSM; a flush mid-burst lets the burst finish but keeps the rest of it invalid.
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        discard_d    = discard_q;
        fill_start_c = 1'b0;
        case (state_q)
            st_lookup: begin
                if (req_vld_q && !hit_c) begin
                    state_d      = st_fill;
                    mem_req_d    = 1'b1;
                    mem_addr_d   = {addr_q[ADDR_W-1:BURST_BITS], BURST_BITS'(0)};
                    discard_d    = 1'b0;
                    fill_start_c = 1'b1;
                end
            end
            st_fill: begin
                if (bus.flush) begin
                    discard_d = 1'b1;
                end
                if (bus.mem_ack) begin
                    mem_addr_d = {mem_addr_q[ADDR_W-1:BURST_BITS], burst_nxt_c};
                    if (last_word_c) begin
                        state_d   = st_resume;
                        mem_req_d = 1'b0;
                    end
                end
            end
            st_resume: begin
                state_d   = st_lookup;
                discard_d = 1'b0;
            end
            default: state_d = st_lookup;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        if (wr_en_c) begin
            valid_d[fill_idx_c] = !discard_q;
        end
        if (bus.flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= st_lookup;
            addr_q     <= '0;
            req_vld_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_tag_q   <= '0;
            valid_q    <= '0;
            line_q     <= '0;
            miss_q     <= 1'b1;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            req_vld_q  <= req_vld_d;
            rd_data_q  <= rd_data_d;
            rd_tag_q   <= rd_tag_d;
            valid_q    <= valid_d;
            line_q     <= line_d;
            miss_q     <= miss_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            discard_q  <= discard_d;
        end
    end

    // Storage arrays: no reset, validity lives in valid_q.
    always_ff @(posedge CLK) begin
        if (wr_en_c) begin
            data_ram[fill_idx_c] <= bus.mem_data;
            tag_ram[fill_idx_c]  <= mem_addr_q[ADDR_W-1:INDEX_BITS];
        end
    end

    assign bus.cache_line = line_q;
    assign bus.cache_miss = miss_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit_out_c && (hit_cnt_q != 16'hFFFF)) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
        end
        if (fill_start_c && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
        if (bus.flush) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif
endmodule
